// File: rtl/decoder_pkg.sv
// Shared definitions for the receive decoder/arbiter: word type and parity helper.
package decoder_pkg;

  localparam int DEC_DATA_WIDTH = 8;

  // Parity helper input width; narrower payloads are zero-extended, which
  // leaves the XOR reduction unchanged.
  localparam int DEC_PARITY_MAX_W = 32;

  // One received word: parity bit in the MSB, payload below it.
  typedef logic [DEC_DATA_WIDTH:0] dec_word_t;

  // Even parity bit for a payload: the XOR of all its bits.
  function automatic logic dec_even_parity(input logic [DEC_PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic combinational round-robin picker: first asserted request at or
// after ptr, wrapping modulo NUM_REQ. Pointer storage lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] idx,
  output logic                any
);

  // Scan candidates in priority order starting at ptr; the first hit wins.
  always_comb begin
    int cand;
    cand = 0;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = ID_WIDTH'(cand);
      end
    end
  end

endmodule

// File: rtl/decoder_arbiter.sv
// Round-robin arbiter sharing one parity-check stage among NUM_REQ requesters,
// with a registered, backpressured output stage.
// Optional per-requester saturating error counters: DECODER_ARBITER_ERRCNT_EN.
import decoder_pkg::*;

module decoder_arbiter #(
  parameter int DATA_WIDTH    = DEC_DATA_WIDTH,
  parameter int NUM_REQ       = 4,
  parameter int ID_WIDTH      = 2,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_word,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_byte,
  output logic                             out_err,
  output logic [ID_WIDTH-1:0]              out_id
`ifdef DECODER_ARBITER_ERRCNT_EN
  ,
  input  logic                             err_clr,
  output logic [NUM_REQ*ERR_CNT_WIDTH-1:0] err_cnt
`endif
);

  localparam int WORD_W = DATA_WIDTH + 1;

  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] ptr_next;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_WIDTH-1:0] win_idx;
  logic                win_any;
  logic                can_accept;
  logic                xfer;
  logic [WORD_W-1:0]   sel_word;
  logic                sel_err;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // The output slot is free when empty or being drained this cycle.
  assign can_accept = !out_valid || out_ready;
  // Grant is suppressed during reset and while the output is stalled.
  assign req_ready  = (arst || !can_accept) ? '0 : gnt;
  assign xfer       = win_any && can_accept && !arst;

  // Only the winner's word is looked at; parity is checked inline.
  assign sel_word = req_word[win_idx*WORD_W +: WORD_W];
  assign sel_err  = sel_word[DATA_WIDTH] !=
                    dec_even_parity(DEC_PARITY_MAX_W'(sel_word[DATA_WIDTH-1:0]));

  // Pointer moves to the slot after the winner, wrapping at NUM_REQ.
  assign ptr_next = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + ID_WIDTH'(1);

  // Output stage: load on transfer, drop valid when drained with nothing new.
  always_ff @(posedge clk) begin
    if (arst) begin
      out_valid <= 1'b0;
      out_byte  <= '0;
      out_err   <= 1'b0;
      out_id    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_byte  <= sel_word[DATA_WIDTH-1:0];
      out_err   <= sel_err;
      out_id    <= win_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer advances only on an actual transfer.
  always_ff @(posedge clk) begin
    if (arst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= ptr_next;
    end
  end

`ifdef DECODER_ARBITER_ERRCNT_EN
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_errcnt
      logic [ERR_CNT_WIDTH-1:0] cnt_reg;

      // Saturating count of bad-parity transfers; clear beats increment.
      always_ff @(posedge clk) begin
        if (arst || err_clr) begin
          cnt_reg <= '0;
        end else if (xfer && win_idx == ID_WIDTH'(gi) && sel_err && cnt_reg != '1) begin
          cnt_reg <= cnt_reg + ERR_CNT_WIDTH'(1);
        end
      end

      assign err_cnt[gi*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = cnt_reg;
    end
  endgenerate
`endif

endmodule
